// File: rtl/frame_capture_ctrl.sv
// rtl/frame_capture_ctrl.sv - live/arm/capture/hold sequencer for the camera frame buffer write path
// Optional watchdog: define CAPTURE_TIMEOUT_EN to abort a stalled ARM/CAPTURE back to LIVE.
module frame_capture_ctrl #(
    parameter int FRAME_PIXELS   = 76800,
    parameter int NUM_FILTERS    = 6,
    parameter int SEL_W          = 3,
    parameter int TIMEOUT_CYCLES = 4500000
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             capture_in,
    input  logic             release_in,
    input  logic             left_in,
    input  logic             right_in,
    input  logic             frame_done_in,
    input  logic             pixel_valid_in,
    output logic             wr_en_out,
    output logic             frozen_out,
    output logic [1:0]       state_out,
    output logic [SEL_W-1:0] filter_sel_out,
    output logic [16:0]      pixels_written_out,
    output logic             capture_done_out,
    output logic             timeout_out
);

    typedef enum logic [1:0] {
        LIVE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [16:0]      FRAME_MAX = 17'(FRAME_PIXELS);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_FILTERS - 1);

    if ((1 << SEL_W) < NUM_FILTERS || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("frame_capture_ctrl: invalid parameters");
    end

    state_t           state;
    logic [16:0]      count;
    logic [SEL_W-1:0] filter_sel;
    logic             capture_done;
    logic             timeout_pulse;
    logic             capture_prev, release_prev, left_prev, right_prev;
    logic             capture_ev, release_ev, left_ev, right_ev;
    logic             below_max;
    logic             wd_expire;

    assign capture_ev = capture_in & ~capture_prev;
    assign release_ev = release_in & ~release_prev;
    assign left_ev    = left_in    & ~left_prev;
    assign right_ev   = right_in   & ~right_prev;
    assign below_max  = (count < FRAME_MAX);

`ifdef CAPTURE_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_count;
    logic            arm_entry;

    // Counter restarts on every entry to ARM, including re-capture from HOLD.
    assign arm_entry = capture_ev & ((state == LIVE) | ((state == HOLD) & ~release_ev));
    assign wd_expire = ((state == ARM) | (state == CAPTURE)) & (wd_count >= WD_LAST);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wd_count <= '0;
        end else if (arm_entry) begin
            wd_count <= '0;
        end else if (state == ARM || state == CAPTURE) begin
            wd_count <= wd_count + WD_W'(1);
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        wr_en_out = 1'b0;
        case (state)
            LIVE, ARM: wr_en_out = pixel_valid_in;
            CAPTURE:   wr_en_out = pixel_valid_in & below_max;
            default:   wr_en_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state         <= LIVE;
            filter_sel    <= '0;
            count         <= '0;
            capture_done  <= 1'b0;
            timeout_pulse <= 1'b0;
            capture_prev  <= 1'b1;
            release_prev  <= 1'b1;
            left_prev     <= 1'b1;
            right_prev    <= 1'b1;
        end else begin
            capture_prev  <= capture_in;
            release_prev  <= release_in;
            left_prev     <= left_in;
            right_prev    <= right_in;
            capture_done  <= 1'b0;
            timeout_pulse <= 1'b0;
            case (state)
                LIVE: begin
                    if (capture_ev) state <= ARM;
                end
                ARM: begin
                    if (frame_done_in) begin
                        state <= CAPTURE;
                        count <= '0;
                    end else if (wd_expire) begin
                        state         <= LIVE;
                        timeout_pulse <= 1'b1;
                    end
                end
                CAPTURE: begin
                    // A frame boundary landing on the timeout cycle still completes the capture.
                    if (wd_expire && !frame_done_in) begin
                        state         <= LIVE;
                        timeout_pulse <= 1'b1;
                    end else begin
                        if (pixel_valid_in && below_max) count <= count + 17'd1;
                        if (frame_done_in) begin
                            state        <= HOLD;
                            capture_done <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (right_ev && !left_ev) begin
                        filter_sel <= (filter_sel == SEL_LAST) ? '0 : filter_sel + SEL_W'(1);
                    end else if (left_ev && !right_ev) begin
                        filter_sel <= (filter_sel == '0) ? SEL_LAST : filter_sel - SEL_W'(1);
                    end
                    if (release_ev)      state <= LIVE;
                    else if (capture_ev) state <= ARM;
                end
                default: state <= LIVE;
            endcase
        end
    end

    assign frozen_out         = (state == HOLD);
    assign state_out          = state;
    assign filter_sel_out     = filter_sel;
    assign pixels_written_out = count;
    assign capture_done_out   = capture_done;
    assign timeout_out        = timeout_pulse;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb/tb_frame_capture_ctrl.sv - randomized directed bench for frame_capture_ctrl against a rule-level model
module tb_frame_capture_ctrl;

    localparam int FP = 128;
    localparam int NF = 6;
    localparam int SW = 3;
    localparam int TO = 50;
`ifdef CAPTURE_TIMEOUT_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, cap, rel, lft, rgt, fd, pv;
    logic          wr_en, frozen, cdone, tout;
    logic [1:0]    state;
    logic [SW-1:0] sel;
    logic [16:0]   pix;

    always #5 clk = ~clk;

    frame_capture_ctrl #(
        .FRAME_PIXELS(FP), .NUM_FILTERS(NF), .SEL_W(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .capture_in(cap), .release_in(rel),
        .left_in(lft), .right_in(rgt), .frame_done_in(fd), .pixel_valid_in(pv),
        .wr_en_out(wr_en), .frozen_out(frozen), .state_out(state),
        .filter_sel_out(sel), .pixels_written_out(pix),
        .capture_done_out(cdone), .timeout_out(tout)
    );

    int checks = 0;
    int errors = 0;

    // Model: state number (0 live, 1 arm, 2 capture, 3 hold), filter, count, cycles since arm entry.
    int ms, msel, mcnt, mwd;
    bit pc, prl, pl, pr, mdone, mto;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        chk("state", 32'(state), ms);
        chk("frozen", 32'(frozen), 32'(ms == 3));
        chk("filter_sel", 32'(sel), msel);
        chk("pixels_written", 32'(pix), mcnt);
        chk("capture_done", 32'(cdone), 32'(mdone));
        chk("timeout", 32'(tout), 32'(mto));
    endtask

    task automatic model_reset();
        ms = 0; msel = 0; mcnt = 0; mwd = 0;
        pc = 1'b1; prl = 1'b1; pl = 1'b1; pr = 1'b1;
        mdone = 1'b0; mto = 1'b0;
    endtask

    task automatic do_reset(input int n, input bit c);
        rst_n = 1'b0; cap = c; rel = 1'b0; lft = 1'b0; rgt = 1'b0; fd = 1'b0; pv = rb();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        model_reset();
        check_outs();
    endtask

    // One clock: drive inputs, check write gating before the edge, advance model, check after the edge.
    task automatic cyc(input bit c, input bit re, input bit le, input bit ri, input bit f, input bit p);
        bit ce, rle, lev, rev, ewr;
        cap = c; rel = re; lft = le; rgt = ri; fd = f; pv = p;
        #2;
        ewr = (ms == 3) ? 1'b0 : (ms == 2) ? (p && mcnt < FP) : p;
        chk("wr_en", 32'(wr_en), 32'(ewr));
        ce = c && !pc; rle = re && !prl; lev = le && !pl; rev = ri && !pr;
        pc = c; prl = re; pl = le; pr = ri;
        mdone = 1'b0; mto = 1'b0;
        if (ms == 1 || ms == 2) mwd++;
        case (ms)
            0: if (ce) begin ms = 1; mwd = 0; end
            1: begin
                if (f) begin ms = 2; mcnt = 0; end
                else if (WD_ON && mwd >= TO) begin ms = 0; mto = 1'b1; end
            end
            2: begin
                if (WD_ON && mwd >= TO && !f) begin
                    ms = 0; mto = 1'b1;
                end else begin
                    if (p && mcnt < FP) mcnt++;
                    if (f) begin ms = 3; mdone = 1'b1; end
                end
            end
            default: begin
                if (rev && !lev) msel = (msel + 1) % NF;
                else if (lev && !rev) msel = (msel + NF - 1) % NF;
                if (rle) ms = 0;
                else if (ce) begin ms = 1; mwd = 0; end
            end
        endcase
        @(posedge clk); #1;
        check_outs();
    endtask

    initial begin
        int n;
        // Reset with capture held: no arm until it falls and rises again.
        do_reset(3, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, rb());
        cyc(0, 0, 0, 0, 0, rb());
        cyc(1, 0, 0, 0, 0, rb());

        // Capture flow: 5 valids in ARM, frame boundary, 100 valids, frame boundary.
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1, 0);
        n = 0;
        for (int i = 0; i < 400 && n < 100; i++) begin
            bit p;
            p = ($urandom_range(0, 3) != 0);
            cyc(0, 0, 0, 0, 0, p);
            n += int'(p);
        end
        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);

        // Filter select: 7 rights, 2 lefts, simultaneous, then random button activity.
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, 1, 0, rb());
            cyc(0, 0, 0, 0, 0, rb());
        end
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 1, 0, 0, rb());
            cyc(0, 0, 0, 0, 0, rb());
        end
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) cyc(0, 0, rb(), rb(), 0, rb());
        cyc(0, 0, 0, 0, 0, 0);

        // Release and capture together: release wins.
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Saturation: 140 valids then a boundary carrying one more valid.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 140; i++) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1);

        // Random re-captures from HOLD.
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 0, rb());
            cyc(1, 0, 0, 0, rb(), rb());
            for (int i = 0; i < int'($urandom_range(0, 6)); i++) cyc(rb(), 0, 0, 0, 0, rb());
            cyc(0, 0, 0, 0, 1, rb());
            for (int i = 0; i < int'($urandom_range(5, 160)); i++) cyc(rb(), rb(), rb(), rb(), 0, rb());
            cyc(0, 0, 0, 0, 1, 1);
            cyc(0, 0, 0, 1, 0, 0);
        end

        // Reset in the middle of a capture discards the partial count and filter.
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0, 0, 1);
        do_reset(1, 1'b0);

        // Watchdog: arm with no frame boundary.
        cyc(0, 0, 0, 0, 0, rb());
        cyc(1, 0, 0, 0, 0, rb());
        for (int i = 0; i < 60; i++) cyc(0, 0, 0, 0, 0, rb());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
